// File: rtl/pong_game_engine.sv
// rtl/pong_game_engine.sv - Pong game core: encoder paddle, frame-rate ball motion, game FSM, 3:3:2 pixel colour
module pong_game_engine #(
    parameter int H_ACTIVE         = 640,
    parameter int V_ACTIVE         = 480,
    parameter int BORDER           = 4,
    parameter int PADDLE_W         = 120,
    parameter int PADDLE_Y         = 440,
    parameter int BALL_SIZE        = 8,
    parameter int PADDLE_STEP      = 4,
    parameter int BALL_STEP_MIN    = 2,
    parameter int BALL_STEP_MAX    = 6,
    parameter int HITS_PER_SPEEDUP = 8,
    parameter int MISS_FRAMES      = 63,
    parameter int LIVES            = 3
) (
    input  logic       clk25,
    input  logic       Reset,
    input  logic [9:0] xpos,
    input  logic [9:0] ypos,
    input  logic       rota,
    input  logic       rotb,
    input  logic       serve,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue,
    output logic [7:0] score,
    output logic [2:0] lives_left,
    output logic       game_over
);

    localparam logic [9:0] H_MAX      = 10'(H_ACTIVE);
    localparam logic [9:0] V_MAX      = 10'(V_ACTIVE);
    localparam logic [9:0] BRD        = 10'(BORDER);
    localparam logic [9:0] PAD_MAX    = 10'(H_ACTIVE - PADDLE_W);
    localparam logic [9:0] PAD_INIT   = 10'((H_ACTIVE - PADDLE_W) / 2);
    localparam logic [9:0] PAD_STEP   = 10'(PADDLE_STEP);
    localparam logic [9:0] PAD_WID    = 10'(PADDLE_W);
    localparam logic [9:0] PAD_TOP    = 10'(PADDLE_Y);
    localparam logic [9:0] PAD_BOT    = 10'(PADDLE_Y + 8);
    localparam logic [9:0] BSZ        = 10'(BALL_SIZE);
    localparam logic [9:0] BALL_X0    = 10'((H_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_Y0    = 10'((V_ACTIVE - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_X_MAX = 10'(H_ACTIVE - BORDER - BALL_SIZE);
    localparam logic [9:0] BALL_Y_LIM = 10'(1023 - BALL_SIZE);
    localparam logic [2:0] SPD_MIN    = 3'(BALL_STEP_MIN);
    localparam logic [2:0] SPD_MAX    = 3'(BALL_STEP_MAX);
    localparam logic [7:0] HITS       = 8'(HITS_PER_SPEEDUP);
    localparam logic [7:0] MISS_T     = 8'(MISS_FRAMES);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    typedef enum logic [1:0] {S_SERVE, S_PLAY, S_MISS, S_OVER} state_t;

    state_t     state, state_nxt;
    logic [2:0] a_sr, b_sr;
    logic [9:0] paddle_x, ball_x, ball_y;
    logic       dir_x, dir_down;
    logic [2:0] speed;
    logic [7:0] hit_cnt, miss_timer;
    logic       bx_f, by_f, hit_f, miss_f;

    // ---------------- encoder and paddle ----------------
    logic enc_move, enc_up;
    assign enc_move = a_sr[2] ^ a_sr[1] ^ b_sr[2] ^ b_sr[1];
    assign enc_up   = a_sr[2] ^ b_sr[1];

    always_ff @(posedge clk25) begin
        if (Reset) begin
            a_sr     <= 3'd0;
            b_sr     <= 3'd0;
            paddle_x <= PAD_INIT;
        end else begin
            a_sr <= {a_sr[1:0], rota};
            b_sr <= {b_sr[1:0], rotb};
            if (enc_move) begin
                if (enc_up)
                    paddle_x <= (paddle_x >= PAD_MAX - PAD_STEP) ? PAD_MAX : paddle_x + PAD_STEP;
                else
                    paddle_x <= (paddle_x <= PAD_STEP) ? 10'd0 : paddle_x - PAD_STEP;
            end
        end
    end

    // ---------------- pixel terms ----------------
    logic visible, wall, bottom, paddle_px, ball_px, background, flash, tick;
    logic contact_x, contact_t;

    assign tick    = (xpos == 10'd0) && (ypos == V_MAX);
    assign visible = (xpos < H_MAX) && (ypos < V_MAX);
    assign wall    = visible & ((xpos < BRD) | (xpos >= H_MAX - BRD) | (ypos < BRD));
    assign bottom  = visible & (ypos >= V_MAX - BRD);

    // The ball is clamped flush against the walls, so contact is the first
    // pixel column/row just inside each wall.
    assign contact_x = visible & ((xpos <= BRD) | (xpos >= H_MAX - BRD - 10'd1));
    assign contact_t = visible & (ypos <= BRD);

    assign paddle_px = visible & (xpos >= paddle_x) & (xpos < paddle_x + PAD_WID)
                     & (ypos >= PAD_TOP) & (ypos < PAD_BOT);
    assign ball_px   = visible & (state != S_OVER)
                     & (xpos >= ball_x) & (xpos < ball_x + BSZ)
                     & (ypos >= ball_y) & (ypos < ball_y + BSZ);
    assign background = visible & ~(wall | paddle_px | ball_px);
    assign flash      = visible & ((state == S_MISS) | ((state == S_OVER) & ypos[4]));

    // ---------------- collision flags ----------------
    always_ff @(posedge clk25) begin
        if (Reset || tick) begin
            bx_f   <= 1'b0;
            by_f   <= 1'b0;
            hit_f  <= 1'b0;
            miss_f <= 1'b0;
        end else if (state == S_PLAY) begin
            if (ball_px & contact_x) bx_f <= 1'b1;
            if (ball_px & contact_t) by_f <= 1'b1;
            if (ball_px & paddle_px & dir_down) begin
                by_f  <= 1'b1;
                hit_f <= 1'b1;
            end
            if (ball_px & bottom) miss_f <= 1'b1;
        end
    end

    // ---------------- state machine ----------------
    logic go_play, do_step, do_miss, miss_done, restart;

    always_ff @(posedge clk25) begin
        if (Reset) state <= S_SERVE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        go_play   = 1'b0;
        do_step   = 1'b0;
        do_miss   = 1'b0;
        miss_done = 1'b0;
        restart   = 1'b0;
        if (tick) begin
            case (state)
                S_SERVE: if (serve) begin
                    state_nxt = S_PLAY;
                    go_play   = 1'b1;
                end
                S_PLAY: if (miss_f) begin
                    do_miss   = 1'b1;
                    state_nxt = (lives_left == 3'd1) ? S_OVER : S_MISS;
                end else begin
                    do_step = 1'b1;
                end
                S_MISS: if (miss_timer <= 8'd1) begin
                    state_nxt = S_SERVE;
                    miss_done = 1'b1;
                end
                S_OVER: if (serve) begin
                    state_nxt = S_SERVE;
                    restart   = 1'b1;
                end
                default: state_nxt = S_SERVE;
            endcase
        end
    end

    assign game_over = (state == S_OVER);

    // ---------------- ball step ----------------
    logic        nxt_dir_x, nxt_dir_down;
    logic [9:0]  spd10, step_x, step_y;
    logic [10:0] x_sum, y_sum;

    assign nxt_dir_x    = dir_x ^ bx_f;
    assign nxt_dir_down = dir_down ^ by_f;
    assign spd10        = {7'd0, speed};
    assign x_sum        = {1'b0, ball_x} + {1'b0, spd10};
    assign y_sum        = {1'b0, ball_y} + {1'b0, spd10};

    always_comb begin
        step_x = ball_x;
        step_y = ball_y;
        if (nxt_dir_x)
            step_x = (x_sum > {1'b0, BALL_X_MAX}) ? BALL_X_MAX : x_sum[9:0];
        else
            step_x = (ball_x < BRD + spd10) ? BRD : ball_x - spd10;
        if (nxt_dir_down)
            step_y = (y_sum > {1'b0, BALL_Y_LIM}) ? BALL_Y_LIM : y_sum[9:0];
        else
            step_y = (ball_y < BRD + spd10) ? BRD : ball_y - spd10;
    end

    always_ff @(posedge clk25) begin
        if (Reset) begin
            ball_x     <= BALL_X0;
            ball_y     <= BALL_Y0;
            dir_x      <= 1'b1;
            dir_down   <= 1'b0;
            speed      <= SPD_MIN;
            score      <= 8'd0;
            lives_left <= LIVES_INIT;
            hit_cnt    <= 8'd0;
            miss_timer <= 8'd0;
        end else begin
            if (go_play) begin
                dir_x    <= 1'b1;
                dir_down <= 1'b0;
            end
            if (do_step) begin
                dir_x    <= nxt_dir_x;
                dir_down <= nxt_dir_down;
                ball_x   <= step_x;
                ball_y   <= step_y;
                if (hit_f) begin
                    if (score != 8'hFF) score <= score + 8'd1;
                    if (hit_cnt + 8'd1 >= HITS) begin
                        hit_cnt <= 8'd0;
                        speed   <= (speed >= SPD_MAX) ? SPD_MAX : speed + 3'd1;
                    end else begin
                        hit_cnt <= hit_cnt + 8'd1;
                    end
                end
            end
            if (do_miss) begin
                lives_left <= lives_left - 3'd1;
                miss_timer <= MISS_T;
            end
            if (tick && state == S_MISS && miss_timer != 8'd0)
                miss_timer <= miss_timer - 8'd1;
            if (miss_done || restart) begin
                ball_x  <= BALL_X0;
                ball_y  <= BALL_Y0;
                speed   <= SPD_MIN;
                hit_cnt <= 8'd0;
            end
            if (restart) begin
                score      <= 8'd0;
                lives_left <= LIVES_INIT;
            end
        end
    end

    // ---------------- registered colour ----------------
    always_ff @(posedge clk25) begin
        if (Reset) begin
            red   <= 3'd0;
            green <= 3'd0;
            blue  <= 2'd0;
        end else begin
            red   <= {flash | wall | paddle_px, 2'b00};
            green <= {~flash & (wall | paddle_px | ball_px), 2'b00};
            blue  <= {~flash & (wall | ball_px), background & (xpos[5] ^ ypos[5])};
        end
    end

endmodule

// File: tb/tb_pong_game_engine.sv
// tb/tb_pong_game_engine.sv - directed self-checking bench for pong_game_engine
module tb_pong_game_engine;

    logic       clk25 = 1'b0;
    logic       Reset;
    logic [9:0] xpos, ypos;
    logic       rota, rotb, serve;
    logic [2:0] red, green;
    logic [1:0] blue;
    logic [7:0] score;
    logic [2:0] lives_left;
    logic       game_over;

    int tests = 0;
    int fails = 0;
    logic [1:0] enc_idx = 2'd0;

    pong_game_engine dut (
        .clk25(clk25), .Reset(Reset), .xpos(xpos), .ypos(ypos),
        .rota(rota), .rotb(rotb), .serve(serve),
        .red(red), .green(green), .blue(blue),
        .score(score), .lives_left(lives_left), .game_over(game_over)
    );

    always #20 clk25 = ~clk25;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pix(input int x, input int y);
        xpos = 10'(x);
        ypos = 10'(y);
        @(negedge clk25);
    endtask

    // One frame: optional collision probes (top contact, paddle top row,
    // bottom band, all under the ball's right-wall column), then frame_tick.
    task automatic frame(input bit pp, input bit pb, input bit pt);
        if (pt) pix(630, 4);
        if (pp) pix(630, 440);
        if (pb) pix(630, 476);
        pix(0, 480);
        xpos = 10'd700;
        ypos = 10'd500;
    endtask

    // Gray sequence 00,01,11,10 moves the paddle right when stepped forward.
    task automatic enc(input bit up);
        enc_idx = up ? enc_idx + 2'd1 : enc_idx - 2'd1;
        rota = enc_idx[1];
        rotb = enc_idx[1] ^ enc_idx[0];
        repeat (4) @(negedge clk25);
    endtask

    initial begin
        Reset = 1'b1; serve = 1'b0; rota = 1'b0; rotb = 1'b0;
        xpos = 10'd0; ypos = 10'd0;
        repeat (3) @(negedge clk25);
        chk("rst_rgb", 16'({red, green, blue}), 16'd0);
        chk("rst_score", 16'(score), 16'd0);
        chk("rst_lives", 16'(lives_left), 16'd3);
        chk("rst_over", 16'(game_over), 16'd0);
        Reset = 1'b0;
        xpos = 10'd700; ypos = 10'd500;

        repeat (3) frame(0, 0, 0);
        pix(0, 0);
        chk("wall_rgb", 16'({red, green, blue}), 16'b100_100_10);
        pix(316, 236);
        chk("ball_centre", 16'({red, green}), 16'b000_100);
        pix(315, 236);
        chk("ball_left_edge", 16'(green), 16'd0);
        chk("serve_score", 16'(score), 16'd0);
        chk("serve_lives", 16'(lives_left), 16'd3);

        for (int i = 0; i < 10; i++) enc(1);
        pix(300, 444); chk("pad300_in", 16'(red), 16'd4);
        pix(299, 444); chk("pad300_out", 16'(red), 16'd0);
        for (int i = 0; i < 200; i++) enc(0);
        pix(119, 444); chk("pad0_in", 16'(red), 16'd4);
        pix(120, 444); chk("pad0_out", 16'(red), 16'd0);
        for (int i = 0; i < 140; i++) enc(1);
        pix(520, 444); chk("pad520_in", 16'(red), 16'd4);
        pix(519, 444); chk("pad520_out", 16'(red), 16'd0);

        // Paddle hits
        serve = 1'b1; frame(0, 0, 0); serve = 1'b0;
        for (int t = 1; t <= 8; t++) begin
            for (int n = 0; n < 1000 && score != 8'(t); n++) frame(1, 0, 1);
            chk("hit_score", 16'(score), 16'(t));
            if (t == 1) begin
                pix(630, 432); chk("bounce_up_in", 16'({red, green}), 16'b000_100);
                pix(630, 431); chk("bounce_up_out", 16'(green), 16'd0);
            end
        end
        frame(0, 0, 0);
        pix(630, 429); chk("speed3_in", 16'(green), 16'd4);
        pix(630, 428); chk("speed3_out", 16'(green), 16'd0);

        // First miss
        for (int n = 0; n < 1000 && lives_left != 3'd2; n++) frame(0, 1, 1);
        chk("miss1_lives", 16'(lives_left), 16'd2);
        pix(320, 240); chk("miss_flash", 16'({red, green}), 16'b100_000);
        repeat (62) frame(0, 0, 0);
        pix(320, 240); chk("miss_flash_62", 16'(red), 16'd4);
        frame(0, 0, 0);
        pix(320, 240); chk("miss_end", 16'({red, green}), 16'b000_100);
        pix(315, 236); chk("miss_recentre", 16'(green), 16'd0);
        serve = 1'b1; frame(0, 0, 0); serve = 1'b0;
        frame(0, 0, 0);
        pix(318, 234); chk("speed2_in", 16'(green), 16'd4);
        pix(317, 234); chk("speed2_out", 16'(green), 16'd0);

        // Second and third miss
        for (int n = 0; n < 1000 && lives_left != 3'd1; n++) frame(0, 1, 1);
        chk("miss2_lives", 16'(lives_left), 16'd1);
        repeat (63) frame(0, 0, 0);
        serve = 1'b1; frame(0, 0, 0); serve = 1'b0;
        for (int n = 0; n < 1000 && game_over != 1'b1; n++) frame(0, 1, 1);
        chk("over_flag", 16'(game_over), 16'd1);
        chk("over_lives", 16'(lives_left), 16'd0);
        pix(320, 16); chk("over_band_on", 16'(red), 16'd4);
        pix(320, 32); chk("over_band_off", 16'(red), 16'd0);
        chk("over_score_kept", 16'(score), 16'd8);
        serve = 1'b1; frame(0, 0, 0); serve = 1'b0;
        chk("restart_score", 16'(score), 16'd0);
        chk("restart_lives", 16'(lives_left), 16'd3);
        chk("restart_over", 16'(game_over), 16'd0);

        // Reset in PLAY with bx latched
        serve = 1'b1; frame(0, 0, 0); serve = 1'b0;
        for (int n = 0; n < 1000 && score != 8'd1; n++) frame(1, 0, 1);
        chk("pre_rst_score", 16'(score), 16'd1);
        repeat (220) frame(0, 0, 0);
        pix(635, 6);
        Reset = 1'b1;
        @(negedge clk25);
        chk("midrst_rgb", 16'({red, green, blue}), 16'd0);
        chk("midrst_score", 16'(score), 16'd0);
        chk("midrst_lives", 16'(lives_left), 16'd3);
        Reset = 1'b0;
        pix(316, 236); chk("midrst_ball", 16'(green), 16'd4);
        serve = 1'b1; frame(0, 0, 0); serve = 1'b0;
        frame(0, 0, 0);
        pix(318, 234); chk("no_bounce_in", 16'(green), 16'd4);
        pix(317, 234); chk("no_bounce_out", 16'(green), 16'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/pong_game_engine.md
Name: pong_game_engine

Overview:
Parametrised Pong game core for the VGA Pong build.
- Inputs: pixel coordinates from the VGA timing generator and the rotary-encoder quadrature pair.
- Computes paddle and ball motion once per frame, with per-pixel collision detection.
- Runs a serve/play/miss/game-over state machine with score and lives.
- Drives registered 8-bit RGB (3:3:2) pixel colour to the VGA output stage.

Parameters:
H_ACTIVE, 640, visible pixels per line
V_ACTIVE, 480, visible lines per frame
BORDER, 4, wall thickness in pixels (top, left, right)
PADDLE_W, 120, paddle width in pixels
PADDLE_Y, 440, paddle top line; paddle height fixed at 8
BALL_SIZE, 8, ball edge length in pixels
PADDLE_STEP, 4, paddle pixels per encoder detent edge
BALL_STEP_MIN, 2, initial ball speed in pixels/frame per axis
BALL_STEP_MAX, 6, speed ceiling
HITS_PER_SPEEDUP, 8, paddle hits per +1 speed step
MISS_FRAMES, 63, red-flash length in frames
LIVES, 3, lives per game (1..7)

Ports:
clk25  in  1  25 MHz pixel clock
Reset  in  1  synchronous, active-high reset
xpos  in  10  current pixel column
ypos  in  10  current pixel line
rota  in  1  encoder phase A, asynchronous
rotb  in  1  encoder phase B, asynchronous
serve  in  1  serve/restart button, already debounced, level
red  out  3  pixel red
green  out  3  pixel green
blue  out  2  pixel blue
score  out  8  paddle-hit count, saturates at 255
lives_left  out  3  remaining lives
game_over  out  1  high in OVER state

Behaviour:
- Reset is synchronous and active-high and applies in any state, mid-frame included. Reset values:
  - paddle = (H_ACTIVE-PADDLE_W)/2; ball at centre ((H_ACTIVE-BALL_SIZE)/2, (V_ACTIVE-BALL_SIZE)/2); ball direction +X, -Y
  - speed = BALL_STEP_MIN; score = 0; lives_left = LIVES; miss timer = 0; state = SERVE
  - red/green/blue = 0; game_over = 0; hit counter = 0; pending bounce flags = 0
- Encoder:
  - rota and rotb each pass through a 3-flop shift register.
  - Movement occurs when A[2]^A[1]^B[2]^B[1] = 1. Direction is +PADDLE_STEP if A[2]^B[1], else -PADDLE_STEP.
  - Clamp to [0, H_ACTIVE-PADDLE_W]; overshoot lands exactly on the bound.
  - Encoder is active in every state.
- frame_tick = (xpos==0 && ypos==V_ACTIVE). All ball, state, score and lives updates happen only on frame_tick.
- Pixel terms (combinational): visible, wall_l, wall_r, wall_t, bottom (ypos >= V_ACTIVE-BORDER), paddle, ball.
- Collision latching on non-tick cycles while state==PLAY:
  - ball&(wall_l|wall_r) sets bx.
  - ball&wall_t sets by.
  - ball&paddle while moving +Y sets by and hit.
  - ball&bottom sets miss.
  - Flags are sticky until the next frame_tick, then cleared.
- State machine (transitions on frame_tick):
  - SERVE: ball held at centre. If serve=1, go to PLAY with direction +X,-Y.
  - PLAY:
    - If miss: lives_left-1 and miss timer = MISS_FRAMES. Go to OVER if lives_left was 1, else to MISS. Miss takes priority over hit in the same frame.
    - Otherwise: toggle X direction if bx and Y direction if by, then step the ball by speed in the new direction.
    - If hit: score+1 (saturating) and hit counter+1. When the counter reaches HITS_PER_SPEEDUP, reset it to 0 and set speed = min(speed+1, BALL_STEP_MAX).
  - MISS: decrement timer. At 0, re-centre the ball, set speed = BALL_STEP_MIN, hit counter = 0, go to SERVE.
  - OVER: game_over=1; ball hidden. When serve=1: score=0, lives_left=LIVES, speed=BALL_STEP_MIN, re-centre, go to SERVE.
- Ball position arithmetic:
  - 10-bit; after stepping, clamp X to [BORDER, H_ACTIVE-BORDER-BALL_SIZE] and Y to >= BORDER. No wrap-around.
  - The bottom edge is not clamped, so a miss is detected in the following frame.
- Colour, registered (1-cycle latency from xpos/ypos); outputs are 0 when not visible:
  - flash = visible & (state==MISS | state==OVER & ypos[4]).
  - red = {flash|wall|paddle, 2'b00}
  - green = {~flash&(wall|paddle|ball), 2'b00}
  - blue = {~flash&(wall|ball), background&(xpos[5]^ypos[5])}
  - background = visible & ~(wall|paddle|ball).

Test Plan:
- Reset then 3 frames with serve=0 -> state SERVE, ball at (316,236), score=0, lives_left=3, pixel (0,0) red=3'b100 green=3'b100 blue=2'b10 one cycle later.
- 10 clockwise quadrature edges from reset -> paddle=300. Then 200 counter-clockwise edges -> paddle=0, with no underflow.
- serve=1, ball forced onto paddle path moving down -> by bounce; Y direction negative next frame; score=1. After 8 such hits -> speed=3, score=8.
- Ball reaches bottom with lives=3 -> lives_left=2, MISS for 63 frames (red full screen), then SERVE with ball centred and speed=2.
- Third miss -> OVER, game_over=1. serve=1 at the next frame_tick -> score=0, lives_left=3, state SERVE.
- Reset asserted mid-line during PLAY with bx latched -> all registers at reset values the next cycle; no bounce is applied at the following frame_tick.
